// File: rtl/seq_mul_pkg.sv
// Shared definitions for the parametrised sequential shift-add multiplier.
//
// Contents:
//   SEQ_MUL_WIDTH_DEF - default operand width
//   seq_mul_state_t   - controller state encoding (IDLE / CALC / DONE)
package seq_mul_pkg;

  localparam int unsigned SEQ_MUL_WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } seq_mul_state_t;

endpackage

// File: rtl/seq_mul_abs.sv
// Combinational two's-complement conditional negate.
// Produces |x| when negate is driven by the sign bit of a sign-extended
// operand, and -x when applying a product sign. Only instantiated when the
// multiplier is built with SEQ_MUL_SIGNED_EN.
//
// Ports:
//   din    [W-1:0]  value to pass through or negate
//   negate          1: dout = -din, 0: dout = din
//   dout   [W-1:0]  result, truncated to W bits
module seq_mul_abs #(
  parameter int unsigned W = 8
) (
  input  logic [W-1:0] din,
  input  logic         negate,
  output logic [W-1:0] dout
);

  always_comb begin
    dout = negate ? (~din + W'(1)) : din;
  end

endmodule

// File: rtl/seq_mul_param.sv
// Parametrised sequential shift-add multiplier with a start/in_ready input
// handshake and an out_valid/out_ready output handshake with backpressure.
// A multiply takes a fixed WIDTH iterations; out_valid rises WIDTH+1 edges
// after the accepting edge.
//
// Build option:
//   SEQ_MUL_SIGNED_EN - operands treated as two's complement; magnitudes are
//                       multiplied and the product sign applied at the end.
//                       Undefined: purely unsigned.
//
// Ports:
//   CLK                 rising-edge clock
//   reset               synchronous, active-high reset
//   start               begin a multiply (accepted only while in_ready=1)
//   in_a   [WIDTH-1:0]  multiplicand, captured on the accepting edge
//   in_b   [WIDTH-1:0]  multiplier, captured on the accepting edge
//   in_ready            high only in IDLE
//   out    [2*WIDTH-1:0] registered product, held until overwritten
//   out_valid           high only in DONE
//   out_ready           consumer accepts the result when out_valid & out_ready
module seq_mul_param
  import seq_mul_pkg::*;
#(
  parameter int unsigned WIDTH = SEQ_MUL_WIDTH_DEF
) (
  input  logic                 CLK,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  output logic                 in_ready,
  output logic [2*WIDTH-1:0]   out,
  output logic                 out_valid,
  input  logic                 out_ready
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  localparam int unsigned PW    = 2 * WIDTH;
`ifdef SEQ_MUL_SIGNED_EN
  // One extra bit so the magnitude of -2^(WIDTH-1) is representable.
  localparam int unsigned MAG_W = WIDTH + 1;
`else
  localparam int unsigned MAG_W = WIDTH;
`endif

  seq_mul_state_t   state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [PW-1:0]    acc;
  logic [PW-1:0]    mcand;
  logic [MAG_W-1:0] mplier;

  logic [PW-1:0]    a_load;
  logic [MAG_W-1:0] b_load;
  logic [PW-1:0]    res_final;
  logic             last;

  // Counter reaching WIDTH means all iterations are done; that CALC cycle
  // only transfers the result, giving the fixed WIDTH+1 edge latency.
  assign last = (cnt == CNT_W'(WIDTH));

`ifdef SEQ_MUL_SIGNED_EN
  logic [WIDTH:0] a_mag, b_mag;
  logic           sign_q;

  seq_mul_abs #(.W(WIDTH + 1)) u_abs_a (
    .din    ({in_a[WIDTH-1], in_a}),
    .negate (in_a[WIDTH-1]),
    .dout   (a_mag)
  );

  seq_mul_abs #(.W(WIDTH + 1)) u_abs_b (
    .din    ({in_b[WIDTH-1], in_b}),
    .negate (in_b[WIDTH-1]),
    .dout   (b_mag)
  );

  seq_mul_abs #(.W(PW)) u_neg_res (
    .din    (acc),
    .negate (sign_q),
    .dout   (res_final)
  );

  assign a_load = PW'(a_mag);
  assign b_load = b_mag;

  always_ff @(posedge CLK) begin
    if (reset) begin
      sign_q <= 1'b0;
    end else if (state == S_IDLE && start) begin
      sign_q <= in_a[WIDTH-1] ^ in_b[WIDTH-1];
    end
  end
`else
  assign a_load    = PW'(in_a);
  assign b_load    = in_b;
  assign res_final = acc;
`endif

  // State register
  always_ff @(posedge CLK) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; unused encodings fall back to IDLE
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (start)     state_nxt = S_CALC;
      S_CALC: if (last)      state_nxt = S_DONE;
      S_DONE: if (out_ready) state_nxt = S_IDLE;
      default:               state_nxt = S_IDLE;
    endcase
  end

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);

  // Datapath: operand capture, shift-add iterations, result register
  always_ff @(posedge CLK) begin
    if (reset) begin
      cnt    <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      out    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            mcand  <= a_load;
            mplier <= b_load;
            acc    <= '0;
            cnt    <= '0;
          end
        end
        S_CALC: begin
          if (last) begin
            out <= res_final;
          end else begin
            if (mplier[0]) begin
              acc <= acc + mcand;
            end
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_mul_param.sv
// Self-checking bench for seq_mul_param (WIDTH=8). Follows the build option
// SEQ_MUL_SIGNED_EN so the same file covers unsigned and signed builds.
module tb_seq_mul_param;

  localparam int unsigned W  = 8;
  localparam int unsigned PW = 2 * W;

  typedef struct {
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [PW-1:0] p;
  } vec_t;

  logic          CLK = 1'b0;
  logic          reset;
  logic          start;
  logic [W-1:0]  in_a;
  logic [W-1:0]  in_b;
  logic          in_ready;
  logic [PW-1:0] out;
  logic          out_valid;
  logic          out_ready;

  int            n_vec = 0;
  int            n_bad = 0;
  logic [PW-1:0] sb[$];
  vec_t          tbl[$];

  always #5 CLK = ~CLK;

  seq_mul_param #(.WIDTH(W)) dut (
    .CLK       (CLK),
    .reset     (reset),
    .start     (start),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_ready  (in_ready),
    .out       (out),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  function automatic logic [PW-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
    logic signed [PW-1:0] s;
`ifdef SEQ_MUL_SIGNED_EN
    s = $signed(a) * $signed(b);
`else
    s = $signed({{W{1'b0}}, a} * {{W{1'b0}}, b});
`endif
    return s;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [PW-1:0] p);
    int guard = 0;
    while (!in_ready && guard < 50) begin
      @(negedge CLK);
      guard++;
    end
    if (guard >= 50) check("start_wait_in_ready", in_ready, 1);
    in_a  = a;
    in_b  = b;
    start = 1'b1;
    sb.push_back(p);
    @(negedge CLK);
    start = 1'b0;
  endtask

  task automatic wait_valid(output int edges, output bit busy_ok);
    edges   = 0;
    busy_ok = 1'b1;
    while (!out_valid && edges < 40) begin
      @(negedge CLK);
      edges++;
      if (!out_valid && in_ready) busy_ok = 1'b0;
    end
    if (!out_valid) check("out_valid_timeout", out_valid, 1);
  endtask

  task automatic consume(input string name);
    logic [PW-1:0] e;
    if (sb.size() == 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL %s: got result %0h expected none", name, out);
      e = '0;
    end else begin
      e = sb.pop_front();
    end
    check({name, " valid"}, out_valid, 1);
    check({name, " product"}, out, e);
    out_ready = 1'b1;
    @(negedge CLK);
    out_ready = 1'b0;
    check({name, " valid_drop"}, out_valid, 0);
    check({name, " in_ready_back"}, in_ready, 1);
    check({name, " out_hold"}, out, e);
  endtask

  task automatic run_vec(input logic [W-1:0] a, input logic [W-1:0] b, input logic [PW-1:0] p);
    int    edges;
    bit    busy_ok;
    string nm;
    nm = $sformatf("%0h*%0h", a, b);
    start_op(a, b, p);
    wait_valid(edges, busy_ok);
    check({nm, " latency"}, edges, W + 1);
    check({nm, " in_ready_busy"}, busy_ok, 1);
    consume(nm);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int    edges;
    bit    busy_ok;
    bit    seen;
    logic [PW-1:0] bp_exp;

`ifdef SEQ_MUL_SIGNED_EN
    tbl.push_back('{8'hFB, 8'd7,   16'hFFDD});
    tbl.push_back('{8'h80, 8'h80,  16'd16384});
    tbl.push_back('{8'h7F, 8'h80,  16'hC080});
    tbl.push_back('{8'hFF, 8'hFF,  16'd1});
    tbl.push_back('{8'hFF, 8'd1,   16'hFFFF});
    tbl.push_back('{8'd0,  8'hC8,  16'd0});
    tbl.push_back('{8'd3,  8'd9,   16'd27});
`else
    tbl.push_back('{8'd3,   8'd9,   16'd27});
    tbl.push_back('{8'd111, 8'd101, 16'd11211});
    tbl.push_back('{8'd123, 8'd7,   16'd861});
    tbl.push_back('{8'd1,   8'd60,  16'd60});
    tbl.push_back('{8'd255, 8'd255, 16'd65025});
    tbl.push_back('{8'd0,   8'd200, 16'd0});
    tbl.push_back('{8'd1,   8'd1,   16'd1});
    tbl.push_back('{8'd128, 8'd2,   16'd256});
`endif

    reset     = 1'b1;
    start     = 1'b0;
    out_ready = 1'b0;
    in_a      = '0;
    in_b      = '0;
    repeat (3) @(negedge CLK);
    check("reset out", out, 0);
    check("reset out_valid", out_valid, 0);
    check("reset in_ready", in_ready, 1);
    reset = 1'b0;
    @(negedge CLK);
    check("idle in_ready", in_ready, 1);

    // Table-driven products
    for (int i = 0; i < tbl.size(); i++) begin
      run_vec(tbl[i].a, tbl[i].b, tbl[i].p);
    end

    // Backpressure: hold out_ready low for 5 cycles once the result is up
    bp_exp = model(8'd123, 8'd7);
    start_op(8'd123, 8'd7, bp_exp);
    wait_valid(edges, busy_ok);
    check("bp latency", edges, W + 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      check("bp out_valid", out_valid, 1);
      check("bp out", out, bp_exp);
      check("bp in_ready", in_ready, 0);
    end
    consume("bp");

    // Start pulse while busy must be ignored
    start_op(8'd10, 8'd14, model(8'd10, 8'd14));
    repeat (3) @(negedge CLK);
    check("busy in_ready", in_ready, 0);
    in_a  = 8'd50;
    in_b  = 8'd50;
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    wait_valid(edges, busy_ok);
    check("busy latency", edges + 4, W + 1);
    check("busy in_ready_calc", busy_ok, 1);
    consume("busy");
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      if (out_valid) seen = 1'b1;
    end
    check("busy no_second_result", seen, 0);

    // Reset during iteration 4 discards the operation
    start_op(8'd111, 8'd101, model(8'd111, 8'd101));
    repeat (3) @(negedge CLK);
    reset = 1'b1;
    @(negedge CLK);
    reset = 1'b0;
    sb.delete();
    check("midreset out", out, 0);
    check("midreset out_valid", out_valid, 0);
    check("midreset in_ready", in_ready, 1);
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge CLK);
      if (out_valid) seen = 1'b1;
    end
    check("midreset no_result", seen, 0);
    run_vec(8'd10, 8'd14, 16'd140);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
